// File: rtl/npu_sram_pkg.sv
// Shared widths and FSM encoding for the SRAM streaming engines.
package npu_sram_pkg;
  localparam int NPU_ADDR_W = 10;
  localparam int NPU_DATA_W = 8;
  localparam int NPU_LEN_W  = NPU_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_t;
endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry read-return buffer with occupancy count for issue back-pressure.
module sram_rd_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] mem [2];
  logic              wp, rp;
  logic              do_push, do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wp <= ~wp;
      if (do_pop)  rp <= ~rp;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/sram_a_streamer.sv
// Command-driven streamer between a valid/ready stream pair and a single-port SRAM.
module sram_a_streamer
  import npu_sram_pkg::*;
#(
  parameter int ADDR_W = NPU_ADDR_W,
  parameter int DATA_W = NPU_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy,
  output logic              done
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len, issued, popped, issued_nx, popped_nx;
  logic              inflight;
  logic              wr_fire, rd_issue, rd_pop;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [1:0]        fifo_count, occ;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WR);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  assign issued_nx = issued + 1'b1;
  assign popped_nx = popped + 1'b1;

  assign wr_fire  = wr_ready && wr_valid;
  assign rd_pop   = rd_valid && rd_ready;
  // Reads still in the SRAM pipe plus buffered beats, net of this cycle's pop.
  assign occ      = fifo_count + {1'b0, inflight} - {1'b0, rd_pop};
  assign rd_issue = (state == RD) && (issued != len) && (occ < 2'd2);

  assign sram_ce   = wr_fire || rd_issue;
  assign sram_we   = wr_fire;
  assign sram_addr = addr;
  assign sram_din  = wr_data;

  assign fifo_push = inflight;
  assign rd_valid  = (state == RD) && !fifo_empty;
  assign rd_last   = rd_valid && (popped_nx == len);

  sram_rd_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (sram_dout),
    .pop   (rd_pop),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      len      <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      case (state)
        IDLE: if (cmd_valid) begin
          addr   <= cmd_addr;
          len    <= cmd_len;
          issued <= '0;
          popped <= '0;
          if (cmd_len == '0)  state <= FIN;
          else if (cmd_write) state <= WR;
          else                state <= RD;
        end
        WR: if (wr_fire) begin
          addr   <= addr + 1'b1;
          issued <= issued_nx;
          if (issued_nx == len) state <= FIN;
        end
        RD: begin
          if (rd_issue) begin
            addr   <= addr + 1'b1;
            issued <= issued_nx;
          end
          if (rd_pop) begin
            popped <= popped_nx;
            if (popped_nx == len) state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Full is implied by the issue throttle; kept visible to the pipe for clarity.
  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_sram_a_streamer.sv
// Scenario bench for sram_a_streamer with a behavioural SRAM and expectation queues.
module tb_sram_a_streamer;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic          busy, done;

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wacc_t;
  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  wacc_t         wacc_q[$];
  int            n_run = 0, n_fail = 0;

  logic [DW-1:0] mem    [1<<AW];
  logic [DW-1:0] shadow [1<<AW];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout      <= mem[sram_addr];
    end
  end

  sram_a_streamer #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy), .done(done)
  );

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    n_run++;
    if ({busy, done, rd_valid, sram_ce, sram_we, wr_ready} !== 6'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy/done/rd_valid/ce/we/wr_ready=%b cmd_ready=%b, want 000000 1",
               {busy, done, rd_valid, sram_ce, sram_we, wr_ready}, cmd_ready);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d0);
    int beat = 0, last_cyc = -1;
    bit got_done = 0;
    wacc_t w;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = LW'(n);
    #1;
    n_run++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
    for (int i = 0; i < n; i++) begin
      w.addr = a + AW'(i); w.data = d0 + DW'(i);
      wacc_q.push_back(w);
      shadow[w.addr] = w.data;
    end
    for (int c = 1; c < 40 && !got_done; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      wr_valid = (beat < n);
      wr_data = d0 + DW'(beat);
      #1;
      if (sram_ce) begin
        n_run++;
        if (wacc_q.size() != 0) w = wacc_q.pop_front();
        else begin w.addr = 'x; w.data = 'x; end
        if (sram_we !== 1'b1 || sram_addr !== w.addr || sram_din !== w.data) begin
          n_fail++;
          $display("FAIL wr_access: got we=%b addr=%h din=%h want we=1 addr=%h din=%h",
                   sram_we, sram_addr, sram_din, w.addr, w.data);
        end
      end
      if (wr_valid && wr_ready) begin beat++; last_cyc = c; end
      if (done) begin
        got_done = 1;
        n_run++;
        if (c != last_cyc + 1 || beat != n) begin
          n_fail++;
          $display("FAIL wr_done: got done at cycle %0d after %0d beats, want cycle %0d after %0d",
                   c, beat, last_cyc + 1, n);
        end
      end
    end
    n_run++;
    if (!got_done || wacc_q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_complete: got done=%0d leftover=%0d, want done=1 leftover=0", got_done, wacc_q.size());
      wacc_q.delete();
    end
    @(negedge clk); wr_valid = 0; #1;
    n_run++;
    if ({busy, done, sram_ce} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_idle: got busy/done/ce=%b want 000", {busy, done, sram_ce});
    end
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0 repeating
  task automatic test_read(input logic [AW-1:0] a, input int n, input int mode);
    int issued = 0, popped = 0, first_v = -1, first_p = -1, last_p = -1, occ;
    bit got_done = 0, pop, iss;
    beat_t e;
    logic [AW-1:0] ea;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = LW'(n);
    #1;
    n_run++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_cmd_ready: got %b want 1", cmd_ready); end
    for (int i = 0; i < n; i++) begin
      ea = a + AW'(i);
      addr_q.push_back(ea);
      e.data = shadow[ea]; e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    for (int c = 1; c < 200 && !got_done; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      rd_ready = (mode == 0) ? 1'b1 : (((c - 1) % 3) == 0);
      #1;
      pop = rd_valid && rd_ready;
      iss = sram_ce && !sram_we;
      if (sram_ce) begin
        n_run++;
        if (addr_q.size() != 0) ea = addr_q.pop_front(); else ea = 'x;
        if (sram_we !== 1'b0 || sram_addr !== ea) begin
          n_fail++;
          $display("FAIL rd_access: got we=%b addr=%h want we=0 addr=%h", sram_we, sram_addr, ea);
        end
      end
      occ = issued - popped - int'(pop) + int'(iss);
      n_run++;
      if (occ > 2) begin n_fail++; $display("FAIL rd_occupancy: got %0d want <=2", occ); end
      if (rd_valid && first_v < 0) begin
        first_v = c;
        n_run++;
        if (c != 3) begin n_fail++; $display("FAIL rd_latency: got first valid cycle %0d want 3", c); end
      end
      if (pop) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin e.data = 'x; e.last = 1'bx; end
        n_run++;
        if (rd_data !== e.data || rd_last !== e.last) begin
          n_fail++;
          $display("FAIL rd_beat: got data=%h last=%b want data=%h last=%b", rd_data, rd_last, e.data, e.last);
        end
        popped++;
        if (first_p < 0) first_p = c;
        last_p = c;
      end
      issued += int'(iss);
      if (done) begin
        got_done = 1;
        n_run++;
        if (popped != n || c != last_p + 1) begin
          n_fail++;
          $display("FAIL rd_done: got done cycle %0d after %0d beats want cycle %0d after %0d",
                   c, popped, last_p + 1, n);
        end
      end
    end
    n_run++;
    if (!got_done || exp_q.size() != 0 || addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_complete: got done=%0d beats_left=%0d addrs_left=%0d want 1 0 0",
               got_done, exp_q.size(), addr_q.size());
      exp_q.delete(); addr_q.delete();
    end
    if (mode == 0) begin
      n_run++;
      if (last_p - first_p != n - 1) begin
        n_fail++;
        $display("FAIL rd_rate: got %0d cycles for %0d beats want %0d", last_p - first_p + 1, n, n);
      end
    end
    @(negedge clk); rd_ready = 0; #1;
    n_run++;
    if ({busy, done, rd_valid, sram_ce} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rd_idle: got busy/done/rd_valid/ce=%b want 0000", {busy, done, rd_valid, sram_ce});
    end
  endtask

  task automatic test_zero_len(input logic wr);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = 10'h155; cmd_len = '0;
    #1;
    n_run++;
    if (cmd_ready !== 1'b1 || sram_ce !== 1'b0) begin
      n_fail++; $display("FAIL zero_accept: got ready=%b ce=%b want 1 0", cmd_ready, sram_ce);
    end
    @(negedge clk); cmd_valid = 0; wr_valid = 1; rd_ready = 1; #1;
    n_run++;
    if ({done, busy, sram_ce, wr_ready, rd_valid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL zero_fin: got done/busy/ce/wr_ready/rd_valid=%b want 11000",
               {done, busy, sram_ce, wr_ready, rd_valid});
    end
    @(negedge clk); wr_valid = 0; rd_ready = 0; #1;
    n_run++;
    if ({done, busy, sram_ce, cmd_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_idle: got done/busy/ce/cmd_ready=%b want 0001", {done, busy, sram_ce, cmd_ready});
    end
  endtask

  task automatic test_reset_mid_read();
    logic [AW-1:0] a = 10'h100;
    int popped = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = LW'(10);
    for (int c = 0; c < 50 && popped < 2; c++) begin
      @(negedge clk);
      cmd_valid = 0; rd_ready = 1;
      #1;
      if (rd_valid && rd_ready) begin
        n_run++;
        if (rd_data !== shadow[a + AW'(popped)]) begin
          n_fail++;
          $display("FAIL rst_pre_beat: got %h want %h", rd_data, shadow[a + AW'(popped)]);
        end
        popped++;
      end
    end
    n_run++;
    if (popped != 2) begin n_fail++; $display("FAIL rst_pre_progress: got %0d beats want 2", popped); end
    @(negedge clk); rst = 1; #1;
    n_run++;
    if ({busy, done, rd_valid, sram_ce, sram_we, wr_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b want 000000", {busy, done, rd_valid, sram_ce, sram_we, wr_ready});
    end
    repeat (2) @(negedge clk);
    rst = 0; rd_ready = 0;
    @(negedge clk); #1;
    n_run++;
    if ({busy, sram_ce, rd_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_release: got busy/ce/rd_valid=%b want 000", {busy, sram_ce, rd_valid});
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'(i) ^ 8'h5A;
      shadow[i] = DW'(i) ^ 8'h5A;
    end
    test_reset();
    test_write(10'h010, 4, 8'hA1);
    test_read(10'h010, 4, 0);
    test_read(10'h3FE, 4, 0);
    test_read(10'h080, 8, 1);
    test_zero_len(1'b0);
    test_zero_len(1'b1);
    test_write(10'h3FF, 3, 8'h11);
    test_read(10'h3FE, 5, 1);
    test_reset_mid_read();
    test_read(10'h200, 6, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
